// File: rtl/branch_resolve_pkg.sv
// Shared encodings for the execute-stage branch resolution slice:
// comparator ops, control-flow kinds and the resolve FSM states.
package branch_resolve_pkg;

  // Comparator operation codes. Codes 3'b110 and 3'b111 are unused and
  // always compare false.
  localparam logic [2:0] BC_BEQ  = 3'd0;
  localparam logic [2:0] BC_BNE  = 3'd1;
  localparam logic [2:0] BC_BLT  = 3'd2;
  localparam logic [2:0] BC_BGE  = 3'd3;
  localparam logic [2:0] BC_BLTU = 3'd4;
  localparam logic [2:0] BC_BGEU = 3'd5;

  // Control-flow kind of the instruction presented by execute.
  localparam logic [1:0] KIND_NONE   = 2'd0;
  localparam logic [1:0] KIND_BRANCH = 2'd1;
  localparam logic [1:0] KIND_JAL    = 2'd2;
  localparam logic [1:0] KIND_JALR   = 2'd3;

  // Resolve FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REDIRECT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_e;

  // Jumps write a link register; conditional branches do not.
  function automatic logic is_link(input logic [1:0] kind);
    return (kind == KIND_JAL) || (kind == KIND_JALR);
  endfunction

endpackage

// File: rtl/branch_resolve_comp.sv
// Branch comparator: evaluates the branch condition on two operands.
module branch_comp
  import branch_resolve_pkg::*;
(
  input  logic [31:0] data_in1,
  input  logic [31:0] data_in2,
  input  logic [2:0]  bc_op,
  output logic        out
);

  // Select the comparison; unused op codes never report taken.
  always_comb begin
    out = 1'b0;
    case (bc_op)
      BC_BEQ:  out = (data_in1 == data_in2);
      BC_BNE:  out = (data_in1 != data_in2);
      BC_BLT:  out = ($signed(data_in1) <  $signed(data_in2));
      BC_BGE:  out = ($signed(data_in1) >= $signed(data_in2));
      BC_BLTU: out = (data_in1 <  data_in2);
      BC_BGEU: out = (data_in1 >= data_in2);
      default: out = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: decides taken/not-taken, computes the
// target, redirects fetch (which always predicts not-taken), then holds a
// flush of younger instructions for FLUSH_CYCLES cycles.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. ex_valid/ex_ready: upstream holds its instruction while
// ex_ready is low. redirect_valid/redirect_ready: once raised, redirect_valid
// and redirect_pc stay constant until the transfer; redirect_ready while
// redirect_valid is low has no effect.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [1:0]       ex_kind,
  input  logic [2:0]       ex_bc_op,
  input  logic [31:0]      ex_rs1,
  input  logic [31:0]      ex_rs2,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic             flush,
  output logic             link_valid,
  output logic [31:0]      link_data,
  output logic             misalign_exc,
  output logic [31:0]      misalign_addr,
  output logic [CNT_W-1:0] taken_count,
  output logic [1:0]       state_dbg
);

  localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  state_e            state;
  logic [FC_W-1:0]   flush_cnt;
  logic              cmp_out;
  logic              taken;
  logic [31:0]       target;
  logic [31:0]       jalr_sum;

  branch_comp u_comp (
    .data_in1 (ex_rs1),
    .data_in2 (ex_rs2),
    .bc_op    (ex_bc_op),
    .out      (cmp_out)
  );

  assign ex_ready  = (state == ST_IDLE);
  assign state_dbg = state;
  assign jalr_sum  = ex_rs1 + ex_imm;

  // Taken decision and target address of the presented instruction.
  always_comb begin
    taken  = 1'b0;
    target = ex_pc + ex_imm;
    case (ex_kind)
      KIND_BRANCH: taken = cmp_out;
      KIND_JAL:    taken = 1'b1;
      KIND_JALR: begin
        taken  = 1'b1;
        target = {jalr_sum[31:1], 1'b0};
      end
      default:     taken = 1'b0;
    endcase
  end

  // Resolve FSM with registered redirect, flush, link and exception outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      link_valid     <= 1'b0;
      link_data      <= '0;
      misalign_exc   <= 1'b0;
      misalign_addr  <= '0;
      taken_count    <= '0;
    end else begin
      link_valid   <= 1'b0;
      misalign_exc <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ex_valid && taken) begin
            if (target[1:0] != 2'b00) begin
              misalign_exc  <= 1'b1;
              misalign_addr <= target;
            end else begin
              redirect_valid <= 1'b1;
              redirect_pc    <= target;
              flush          <= 1'b1;
              state          <= ST_REDIRECT;
              if (is_link(ex_kind)) begin
                link_valid <= 1'b1;
                link_data  <= ex_pc + 32'd4;
              end
            end
          end
        end
        ST_REDIRECT: begin
          if (redirect_ready) begin
            redirect_valid <= 1'b0;
            if (taken_count != {CNT_W{1'b1}}) begin
              taken_count <= taken_count + CNT_W'(1);
            end
            if (FLUSH_CYCLES == 0) begin
              flush <= 1'b0;
              state <= ST_IDLE;
            end else begin
              flush_cnt <= FC_W'(FLUSH_CYCLES);
              state     <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_cnt <= FC_W'(1)) begin
            flush <= 1'b0;
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - FC_W'(1);
          end
        end
        default: begin
          flush          <= 1'b0;
          redirect_valid <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed cases, randomized traffic against a
// behavioural model, and a small-counter instance for saturation.
module tb_branch_resolve;
  import branch_resolve_pkg::*;

  localparam int FC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT signals ----------------
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [1:0]  ex_kind = '0;
  logic [2:0]  ex_bc_op = '0;
  logic [31:0] ex_rs1 = '0, ex_rs2 = '0, ex_pc = '0, ex_imm = '0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic        flush, link_valid, misalign_exc;
  logic [31:0] link_data, misalign_addr, taken_count;
  logic [1:0]  state_dbg;

  branch_resolve #(.FLUSH_CYCLES(FC), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_kind(ex_kind), .ex_bc_op(ex_bc_op), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready), .flush(flush),
    .link_valid(link_valid), .link_data(link_data), .misalign_exc(misalign_exc),
    .misalign_addr(misalign_addr), .taken_count(taken_count), .state_dbg(state_dbg)
  );

  // ---------------- second DUT: no flush, 2-bit counter ----------------
  logic        v2 = 1'b0, rdy2, rr2 = 1'b1, rv2, fl2, lv2, me2;
  logic [31:0] rpc2, ld2, ma2;
  logic [1:0]  tc2, st2;

  branch_resolve #(.FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ex_valid(v2), .ex_ready(rdy2),
    .ex_kind(KIND_JAL), .ex_bc_op(3'd0), .ex_rs1(32'd0), .ex_rs2(32'd0),
    .ex_pc(32'h0), .ex_imm(32'h8), .redirect_valid(rv2),
    .redirect_pc(rpc2), .redirect_ready(rr2), .flush(fl2),
    .link_valid(lv2), .link_data(ld2), .misalign_exc(me2),
    .misalign_addr(ma2), .taken_count(tc2), .state_dbg(st2)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_redir_q[$];
  logic [31:0] exp_link_q[$];
  logic [31:0] exp_mis_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_pend = 1'b0;
  logic [31:0] m_pend_pc = '0;
  int          m_flush_left = 0;
  logic [31:0] m_count = '0;
  bit          m_link_due = 1'b0;
  bit          m_mis_due = 1'b0;
  logic [31:0] m_tgt;
  bit          m_tk;

  function automatic bit ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < $signed(b);
      3'd3:    return $signed(a) >= $signed(b);
      3'd4:    return a < b;
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Model advances on each edge from the inputs seen at that edge.
  always @(posedge clk) begin
    m_link_due = 1'b0;
    m_mis_due  = 1'b0;
    if (!rst_n) begin
      m_pend = 1'b0;
      m_flush_left = 0;
      m_count = '0;
      exp_redir_q.delete();
      exp_link_q.delete();
      exp_mis_q.delete();
    end else if (m_pend) begin
      if (redirect_ready) begin
        m_pend = 1'b0;
        m_count = m_count + 1;
        m_flush_left = FC;
      end
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (ex_valid) begin
      m_tk  = 1'b0;
      m_tgt = ex_pc + ex_imm;
      case (ex_kind)
        2'd1: m_tk = ref_taken(ex_bc_op, ex_rs1, ex_rs2);
        2'd2: m_tk = 1'b1;
        2'd3: begin m_tk = 1'b1; m_tgt = ex_rs1 + ex_imm; m_tgt[0] = 1'b0; end
        default: m_tk = 1'b0;
      endcase
      if (m_tk) begin
        if (m_tgt % 4 != 0) begin
          m_mis_due = 1'b1;
          exp_mis_q.push_back(m_tgt);
        end else begin
          m_pend = 1'b1;
          m_pend_pc = m_tgt;
          exp_redir_q.push_back(m_tgt);
          if (ex_kind >= 2'd2) begin
            m_link_due = 1'b1;
            exp_link_q.push_back(ex_pc + 32'd4);
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    check("ex_ready", {31'd0, ex_ready}, {31'd0, !(m_pend || m_flush_left > 0)});
    check("flush", {31'd0, flush}, {31'd0, (m_pend || m_flush_left > 0)});
    check("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_pend});
    check("taken_count", taken_count, m_count);
    if (m_pend) check("redirect_pc_held", redirect_pc, m_pend_pc);
    if (redirect_valid === 1'b1 && redirect_ready === 1'b1) begin
      if (exp_redir_q.size() == 0) check("redirect_unexpected", 32'd1, 32'd0);
      else check("redirect_pc", redirect_pc, exp_redir_q.pop_front());
    end
    check("link_valid", {31'd0, link_valid}, {31'd0, m_link_due});
    if (m_link_due && exp_link_q.size() > 0) check("link_data", link_data, exp_link_q.pop_front());
    check("misalign_exc", {31'd0, misalign_exc}, {31'd0, m_mis_due});
    if (m_mis_due && exp_mis_q.size() > 0) check("misalign_addr", misalign_addr, exp_mis_q.pop_front());
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] k, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm);
    logic acc;
    ex_kind = k; ex_bc_op = op; ex_rs1 = a; ex_rs2 = b; ex_pc = pc; ex_imm = imm;
    ex_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      acc = ex_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        ex_valid = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    ex_valid = 1'b0;
  endtask

  logic acc_prev;
  logic [31:0] r;
  int wait_n;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed: taken BLT, then not-taken BLTU back-to-back with BEQ.
    redirect_ready = 1'b1;
    issue(KIND_BRANCH, BC_BLT, 32'hff786510, 32'h1096bc81, 32'h100, 32'h20);
    idle(6);
    issue(KIND_BRANCH, BC_BLTU, 32'hff786510, 32'h1096bc81, 32'h100, 32'h20);
    issue(KIND_BRANCH, BC_BEQ, 32'h12345678, 32'h12345678, 32'h200, 32'hFFFFFFF0);
    idle(6);
    // Jumps: aligned JALR with link, misaligned JAL.
    issue(KIND_JALR, 3'd0, 32'h2001, 32'h0, 32'h40, 32'h3);
    idle(6);
    issue(KIND_JAL, 3'd0, 32'h0, 32'h0, 32'h40, 32'h6);
    idle(3);
    // Unused comparator op on equal operands is not taken.
    issue(KIND_BRANCH, 3'b110, 32'h5, 32'h5, 32'h80, 32'h10);
    issue(KIND_BRANCH, 3'b111, 32'h5, 32'h5, 32'h80, 32'h10);
    idle(2);

    // Backpressure: fetch stalls 3 cycles; a second instruction waits.
    redirect_ready = 1'b0;
    issue(KIND_BRANCH, BC_BNE, 32'h1, 32'h2, 32'h300, 32'h8);
    fork
      begin repeat (3) @(posedge clk); #1 redirect_ready = 1'b1; end
      issue(KIND_JAL, 3'd0, 32'h0, 32'h0, 32'h400, 32'h10);
    join
    idle(6);

    // Wrap, then reset in the middle of the flush window.
    issue(KIND_JAL, 3'd0, 32'h0, 32'h0, 32'hFFFFFFF0, 32'h20);
    wait_n = 0;
    do begin
      @(negedge clk);
      wait_n++;
    end while (!(flush === 1'b1 && redirect_valid === 1'b0) && wait_n < 20);
    if (wait_n >= 20) begin
      checks++;
      errors++;
      $display("FAIL flush_wait: got no flush window expected one within 20 cycles");
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Randomized traffic; upstream holds an instruction until accepted.
    acc_prev = 1'b1;
    for (int c = 0; c < 600; c++) begin
      if (acc_prev || !ex_valid) begin
        ex_valid = ($urandom_range(0, 3) != 0);
        ex_kind  = 2'($urandom_range(0, 3));
        ex_bc_op = 3'($urandom_range(0, 7));
        ex_rs1   = $urandom;
        ex_rs2   = ($urandom_range(0, 3) == 0) ? ex_rs1 : $urandom;
        r = $urandom;
        r[1:0] = 2'b00;
        ex_pc = r;
        ex_imm = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 1024))
                                             : -32'($urandom_range(0, 1024));
        if ($urandom_range(0, 3) != 0) ex_imm[1:0] = 2'b00;
      end
      redirect_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      acc_prev = ex_valid && ex_ready;
      @(posedge clk);
      #1;
    end
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    idle(10);
    check("redir_q_empty", exp_redir_q.size(), 32'd0);
    check("link_q_empty", exp_link_q.size(), 32'd0);
    check("mis_q_empty", exp_mis_q.size(), 32'd0);

    // Saturating 2-bit counter with no flush window.
    for (int i = 0; i < 5; i++) begin
      v2 = 1'b1;
      @(negedge clk);
      check("dut2_ex_ready", {31'd0, rdy2}, 32'd1);
      @(posedge clk);
      #1 v2 = 1'b0;
      @(negedge clk);
      check("dut2_redirect_valid", {31'd0, rv2}, 32'd1);
      check("dut2_redirect_pc", rpc2, 32'h8);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("dut2_taken_count", {30'd0, tc2}, (i + 1 > 3) ? 32'd3 : 32'(i + 1));
      check("dut2_flush", {31'd0, fl2}, 32'd0);
      check("dut2_ex_ready_after", {31'd0, rdy2}, 32'd1);
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
Execute-stage consumer of the branch comparator. It takes a resolved control-flow instruction, instantiates the comparator, computes the target, and issues a PC redirect to fetch over a valid/ready handshake. It then holds a pipeline flush for a fixed number of cycles and stalls execute until the redirect completes. Fetch always predicts not-taken, so only taken branches and jumps redirect.

Parameters:
FLUSH_CYCLES, 2, cycles flush stays high after redirect handshake (0 allowed)
CNT_W, 32, width of taken-redirect performance counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset; all state sampled on rising clk
ex_valid  in  1  execute stage presents an instruction
ex_ready  out  1  block can accept (high only in IDLE)
ex_kind  in  2  0 NONE, 1 BRANCH, 2 JAL, 3 JALR
ex_bc_op  in  3  comparator op (`BEQ..`BGEU from defines.vh)
ex_rs1  in  32  operand 1 / JALR base
ex_rs2  in  32  operand 2
ex_pc  in  32  instruction PC
ex_imm  in  32  sign-extended immediate
redirect_valid  out  1  redirect request to fetch
redirect_pc  out  32  redirect target
redirect_ready  in  1  fetch accepts redirect
flush  out  1  kill younger instructions in IF/ID
link_valid  out  1  one-cycle pulse, write link value to rd
link_data  out  32  ex_pc+4 of accepted JAL/JALR
misalign_exc  out  1  one-cycle pulse, taken target not 4-byte aligned
misalign_addr  out  32  faulting target
taken_count  out  CNT_W  saturating count of completed redirects

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE. All outputs 0 except ex_ready=1. Flush counter and taken_count cleared. A pending redirect is dropped. This applies mid-REDIRECT or mid-FLUSH.
- Accept occurs when ex_valid && ex_ready.
- Taken conditions:
  - BRANCH: taken if comparator out=1.
  - JAL and JALR: always taken.
  - NONE: never taken.
  - bc_op 3'b110/3'b111: comparator returns 0, so the branch is not taken.
- Target arithmetic, mod 2^32, wrap silently:
  - BRANCH/JAL: ex_pc+ex_imm.
  - JALR: (ex_rs1+ex_imm) with bit0 cleared.
- Aligned taken, accepted in cycle N:
  - At N+1: redirect_valid=1, redirect_pc=target, flush=1, state REDIRECT.
  - For JAL/JALR only: link_valid=1 for one cycle at N+1, link_data=ex_pc+4.
- Misaligned taken (target[1:0]!=0), accepted in cycle N:
  - At N+1: misalign_exc=1 for one cycle, misalign_addr=target.
  - No redirect, no link, no flush; state stays IDLE.
- Not-taken or NONE: no output activity; state stays IDLE; a new instruction can be accepted back-to-back.
- REDIRECT state:
  - ex_ready=0, flush=1.
  - redirect_valid and redirect_pc held stable until redirect_ready=1.
  - On handshake: redirect_valid drops next cycle; taken_count increments, saturating at all-ones.
  - Next state is FLUSH with counter=FLUSH_CYCLES, or IDLE if FLUSH_CYCLES=0.
- FLUSH state:
  - flush=1, ex_ready=0; counter decrements each cycle.
  - Counter reaching 1 returns to IDLE next cycle, so flush lasts exactly FLUSH_CYCLES cycles after the handshake cycle.
- Conflicts: redirect_ready high while redirect_valid=0 is ignored. ex_valid during REDIRECT/FLUSH is not accepted; the upstream stage holds.
- State encoding: IDLE, REDIRECT, FLUSH (2 bits).

Decomposition:
- Add to shared defines.vh: kind encodings (KIND_NONE/BRANCH/JAL/JALR) and state encodings; existing `BEQ..`BGEU reused unchanged.
- Sub-module: the existing branch_comp is instantiated inside (data_in1=ex_rs1, data_in2=ex_rs2, bc_op=ex_bc_op). No other sub-modules.

Test Plan:
1. BRANCH `BLT, rs1=32'hff786510, rs2=32'h1096bc81, pc=32'h100, imm=32'h20, redirect_ready=1 -> at N+1 redirect_valid=1, redirect_pc=32'h120, flush=1; flush high exactly 2 cycles after handshake; taken_count=1; ex_ready back to 1 afterwards.
2. Same operands with `BLTU, then `BEQ rs1=rs2=32'h12345678 pc=32'h200 imm=32'hFFFFFFF0 -> first: no redirect, ex_ready stays 1; second: redirect_pc=32'h1F0.
3. JALR rs1=32'h2001, imm=32'h3, pc=32'h40 -> redirect_pc=32'h2004, link_valid pulse, link_data=32'h44. Then JAL pc=32'h40, imm=32'h6 -> misalign_exc pulse, misalign_addr=32'h46, no redirect, no link.
4. Backpressure: taken branch with redirect_ready=0 for 3 cycles -> redirect_valid and redirect_pc held constant, ex_ready=0 throughout; handshake on 4th cycle; new ex_valid is not accepted until IDLE.
5. Wrap and reset: JAL pc=32'hFFFFFFF0, imm=32'h20 -> redirect_pc=32'h10. Assert rst_n=0 one cycle during FLUSH -> next cycle flush=0, redirect_valid=0, ex_ready=1, taken_count=0.
6. CNT_W=2: five completed redirects -> taken_count reads 1,2,3,3,3.
